// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture writer: FSM states,
// trigger-mode encodings and the default sample width.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    localparam logic TRIG_IMMEDIATE = 1'b0;
    localparam logic TRIG_RISING    = 1'b1;

    localparam int ADC_DATA_WIDTH = 16;

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detector: remembers the previous armed sample and flags either the
// first valid sample (immediate) or a signed rising crossing of trig_level.
module adc_trig_detect
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic                         sample_valid,
    input  logic                         eval_en,
    input  logic                         clear,
    input  logic                         trig_mode,
    input  logic signed [DATA_WIDTH-1:0] trig_level,
    output logic                         trig
);

    logic signed [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                         prev_valid_q, prev_valid_d;
    logic                         crossing;

    // A crossing needs a remembered sample below the level and a new one at/above it.
    assign crossing = prev_valid_q && (prev_q < trig_level) && (sample >= trig_level);

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        trig         = 1'b0;
        if (clear) begin
            prev_valid_d = 1'b0;
        end else if (eval_en && sample_valid) begin
            prev_d       = sample;
            prev_valid_d = 1'b1;
            if (trig_mode == TRIG_RISING) begin
                trig = crossing;
            end else begin
                trig = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/adc_capture_writer.sv
// Armed-trigger ADC capture that writes NUM_TO_WRITE samples into a FIFO.
// Optional decimation is enabled by defining ADC_CAPTURE_DECIM_EN.
module adc_capture_writer
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH   = ADC_DATA_WIDTH,
    parameter int NUM_TO_WRITE = 10,
    parameter int CNT_W        = $clog2(NUM_TO_WRITE + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic                         sample_valid,
    input  logic                         arm,
    input  logic                         trig_mode,
    input  logic signed [DATA_WIDTH-1:0] trig_level,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [7:0]                   decim,
`endif
    output logic [DATA_WIDTH-1:0]        din,
    output logic                         wr_en,
    input  logic                         full,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    cap_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;
    logic                   wr_en_q, wr_en_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic                   take;
    logic                   trig;
    logic                   trig_clear;
    logic                   trig_eval;

`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0] phase_q, phase_d;

    function automatic logic [7:0] next_phase(input logic [7:0] p, input logic [7:0] d);
        if (d <= 8'd1 || p >= d - 8'd1) begin
            return 8'd0;
        end
        return p + 8'd1;
    endfunction
`endif

    // Arm in IDLE or ARMED forgets the previous sample; samples on that cycle are not evaluated.
    assign trig_clear = arm && (state_q != CAPTURE);
    assign trig_eval  = (state_q == ARMED) && !arm;

    adc_trig_detect #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_trig (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .eval_en      (trig_eval),
        .clear        (trig_clear),
        .trig_mode    (trig_mode),
        .trig_level   (trig_level),
        .trig         (trig)
    );

    // The final write leaves the counter at NUM_TO_WRITE; the next cycle retires to IDLE with done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        take       = 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
        phase_d    = phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = ARMED;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
                    phase_d    = 8'd0;
`endif
                end
            end
            ARMED: begin
                if (trig) begin
                    take    = 1'b1;
                    state_d = CAPTURE;
`ifdef ADC_CAPTURE_DECIM_EN
                    phase_d = next_phase(8'd0, decim);
`endif
                end
            end
            CAPTURE: begin
                if (cnt_q == CNT_W'(NUM_TO_WRITE)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (sample_valid) begin
`ifdef ADC_CAPTURE_DECIM_EN
                    take    = (phase_q == 8'd0);
                    phase_d = next_phase(phase_q, decim);
`else
                    take    = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                din_d   = sample;
                wr_en_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            din_q      <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ADC_CAPTURE_DECIM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 8'd0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    assign din      = din_q;
    assign wr_en    = wr_en_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_adc_capture_writer.sv
// Directed testbench for adc_capture_writer: a negedge monitor records FIFO
// writes and done pulses, and each scenario task checks them against hand values.
module tb_adc_capture_writer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] sample = '0;
    logic               sample_valid = 1'b0;
    logic               arm = 1'b0;
    logic               trig_mode = 1'b0;
    logic signed [15:0] trig_level = '0;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0]         decim = 8'd1;
`endif
    logic [15:0]        din;
    logic               wr_en;
    logic               full = 1'b0;
    logic               busy;
    logic               done;
    logic               overflow;

    int errors = 0;
    int checks = 0;

    logic [15:0] wq[$];
    int          wcyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    adc_capture_writer #(
        .DATA_WIDTH(16),
        .NUM_TO_WRITE(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .arm          (arm),
        .trig_mode    (trig_mode),
        .trig_level   (trig_level),
`ifdef ADC_CAPTURE_DECIM_EN
        .decim        (decim),
`endif
        .din          (din),
        .wr_en        (wr_en),
        .full         (full),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Record every FIFO write and done pulse away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en === 1'b1) begin
            wq.push_back(din);
            wcyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq.delete();
        wcyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        sample_valid = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input int s);
        sample = 16'(s);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        sample_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (din !== 16'd0) begin errors++; $display("[TB] FAIL reset_din got=%0d exp=0", din); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_immediate();
        clear_log();
        trig_mode = 1'b0;
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL imm_busy_after_arm got=%b exp=1", busy); end
        for (int i = 1; i <= 20; i++) send(i);
        drain();
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL imm_count got=%0d exp=10", wq.size()); end
        for (int k = 0; k < 10 && k < wq.size(); k++) begin
            checks++; if (wq[k] !== 16'(k + 1)) begin errors++; $display("[TB] FAIL imm_din[%0d] got=%0d exp=%0d", k, wq[k], k + 1); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL imm_done_count got=%0d exp=1", done_cnt); end
        if (wcyc.size() == 10) begin
            checks++; if (done_cyc != wcyc[9] + 1) begin errors++; $display("[TB] FAIL imm_done_timing got=%0d exp=%0d", done_cyc, wcyc[9] + 1); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL imm_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_rising();
        clear_log();
        trig_mode = 1'b1;
        trig_level = 16'sd100;
        do_arm();
        send(90); send(95); send(99);
        for (int k = 0; k < 15; k++) send(100 + 5 * k);
        drain();
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL rise_count got=%0d exp=10", wq.size()); end
        for (int k = 0; k < 10 && k < wq.size(); k++) begin
            checks++; if (wq[k] !== 16'(100 + 5 * k)) begin errors++; $display("[TB] FAIL rise_din[%0d] got=%0d exp=%0d", k, wq[k], 100 + 5 * k); end
        end
        // Signal already above the level must first fall below it
        clear_log();
        do_arm();
        repeat (4) send(150);
        checks++; if (wq.size() != 0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rise_above_no_trig got=%0d/%b exp=0/1", wq.size(), busy); end
        send(80);
        for (int k = 0; k < 12; k++) send(120 + k);
        drain();
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL rise_recross_count got=%0d exp=10", wq.size()); end
        if (wq.size() > 0) begin
            checks++; if (wq[0] !== 16'd120) begin errors++; $display("[TB] FAIL rise_recross_first got=%0d exp=120", wq[0]); end
        end
        // Negative threshold exercises the signed compare
        clear_log();
        trig_level = -16'sd10;
        do_arm();
        send(-20);
        for (int k = 0; k < 11; k++) send(-5 + k);
        drain();
        checks++; if (wq.size() == 0 || wq[0] !== 16'(-5)) begin errors++; $display("[TB] FAIL rise_signed_first got=%0d exp=%0d", (wq.size() > 0) ? wq[0] : 16'hxxxx, 16'(-5)); end
    endtask

    task automatic test_full();
        logic [15:0] exp_v [10];
        exp_v = '{16'd1, 16'd2, 16'd3, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
        clear_log();
        trig_mode = 1'b0;
        do_arm();
        for (int i = 1; i <= 20; i++) begin
            full = (i == 4 || i == 5);
            send(i);
        end
        full = 1'b0;
        drain();
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL full_count got=%0d exp=10", wq.size()); end
        for (int k = 0; k < 10 && k < wq.size(); k++) begin
            checks++; if (wq[k] !== exp_v[k]) begin errors++; $display("[TB] FAIL full_din[%0d] got=%0d exp=%0d", k, wq[k], exp_v[k]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_overflow_sticky got=%b exp=1", overflow); end
        do_arm();
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_overflow_clear got=%b exp=0", overflow); end
        for (int i = 1; i <= 12; i++) send(i);
        drain();
    endtask

    task automatic test_reset_mid();
        clear_log();
        trig_mode = 1'b0;
        do_arm();
        for (int i = 1; i <= 4; i++) send(i);
        rst = 1'b1;
        sample = 16'd5;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        rst = 1'b0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_wr_en got=%b exp=0", wr_en); end
        checks++; if (din !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_din got=%0d exp=0", din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        for (int i = 6; i <= 8; i++) send(i);
        drain();
        checks++; if (wq.size() != 4) begin errors++; $display("[TB] FAIL rstmid_partial got=%0d exp=4", wq.size()); end
        clear_log();
        do_arm();
        for (int i = 30; i <= 41; i++) send(i);
        drain();
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL rstmid_fresh_count got=%0d exp=10", wq.size()); end
        if (wq.size() == 10) begin
            checks++; if (wq[9] !== 16'd39) begin errors++; $display("[TB] FAIL rstmid_fresh_last got=%0d exp=39", wq[9]); end
        end
    endtask

    task automatic test_rearm();
        clear_log();
        trig_mode = 1'b1;
        trig_level = 16'sd100;
        do_arm();
        send(95);
        do_arm();
        send(105);
        send(110);
        checks++; if (wq.size() != 0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rearm_straddle got=%0d/%b exp=0/1", wq.size(), busy); end
        send(50);
        for (int k = 0; k < 13; k++) begin
            arm = (k == 3 || k == 7);
            send(100 + k);
            arm = 1'b0;
        end
        drain();
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL rearm_capture_count got=%0d exp=10", wq.size()); end
        for (int k = 0; k < 10 && k < wq.size(); k++) begin
            checks++; if (wq[k] !== 16'(100 + k)) begin errors++; $display("[TB] FAIL rearm_din[%0d] got=%0d exp=%0d", k, wq[k], 100 + k); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL rearm_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        clear_log();
        trig_mode = 1'b0;
        do_arm();
        for (int i = 1; i <= 30 && !seen; i++) begin
            send(i);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_done_timeout got=0 exp=1"); end
        clear_log();
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got=%b exp=1", busy); end
        for (int i = 50; i <= 62; i++) send(i);
        drain();
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=10", wq.size()); end
        if (wq.size() > 0) begin
            checks++; if (wq[0] !== 16'd50) begin errors++; $display("[TB] FAIL b2b_first got=%0d exp=50", wq[0]); end
        end
    endtask

`ifdef ADC_CAPTURE_DECIM_EN
    task automatic test_decim();
        clear_log();
        trig_mode = 1'b0;
        decim = 8'd3;
        do_arm();
        for (int i = 1; i <= 32; i++) send(i);
        drain();
        decim = 8'd1;
        checks++; if (wq.size() != 10) begin errors++; $display("[TB] FAIL decim_count got=%0d exp=10", wq.size()); end
        for (int k = 0; k < 10 && k < wq.size(); k++) begin
            checks++; if (wq[k] !== 16'(1 + 3 * k)) begin errors++; $display("[TB] FAIL decim_din[%0d] got=%0d exp=%0d", k, wq[k], 1 + 3 * k); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_immediate();
        test_rising();
        test_full();
        test_reset_mid();
        test_rearm();
        test_back_to_back();
`ifdef ADC_CAPTURE_DECIM_EN
        test_decim();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_writer.md
# adc_capture_writer

Upstream capture stage of the FIFO-to-AXI4-Stream path. It takes a free-running ADC sample stream, waits for an armed trigger, and then writes exactly NUM_TO_WRITE samples into the synchronous FIFO through its din/wr_en/full ports. The downstream FIFO reader drains the FIFO and emits each burst as one AXI4-Stream packet.

## Interface
Parameters:
- DATA_WIDTH, 16, sample and FIFO word width; samples are two's complement.
- NUM_TO_WRITE, 10, samples written per capture. Legal range is 1 or more; it must equal the reader's packet length.
- CNT_W, $clog2(NUM_TO_WRITE+1), width of the capture counter. Derived; never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- sample  in  DATA_WIDTH  ADC sample, signed.
- sample_valid  in  1  sample qualifier; one cycle per sample.
- arm  in  1  single-cycle arm request.
- trig_mode  in  1  0 = immediate (first valid sample); 1 = rising level crossing.
- trig_level  in  DATA_WIDTH  signed trigger threshold.
- decim  in  8  decimation factor. Present only when ADC_CAPTURE_DECIM_EN is defined.
- din  out  DATA_WIDTH  FIFO write data.
- wr_en  out  1  FIFO write strobe.
- full  in  1  FIFO full flag.
- busy  out  1  high in ARMED and CAPTURE.
- done  out  1  one-cycle pulse when a capture completes.
- overflow  out  1  sticky; set when a sample is dropped because `full` is high.

## Operation
- **States:** IDLE, ARMED, CAPTURE.
- **IDLE:**
  - arm=1 → ARMED.
  - On the same edge: clear overflow, capture counter, decimation phase, and prev_valid.
- **ARMED:**
  - Each sample_valid evaluates the trigger.
  - Mode 0 fires on the first valid sample.
  - Mode 1 fires when prev_valid && prev < trig_level && sample >= trig_level, using signed compares.
  - prev/prev_valid update on every valid sample in ARMED.
  - The triggering sample is the first captured sample; the state moves to CAPTURE on that edge.
  - arm=1 in ARMED re-arms: prev_valid is cleared and the state stays ARMED.
- **CAPTURE:**
  - Each valid sample with decimation phase 0 is a write candidate.
  - If full=0: register din<=sample and wr_en<=1 for one cycle, and increment the counter.
  - If full=1: drop the sample, set overflow=1, and leave the counter unchanged.
  - When the counter reaches NUM_TO_WRITE: go to IDLE and pulse done on the following cycle.
  - arm is ignored.
- **Simultaneous events:**
  - A valid sample arriving on the same cycle as arm in IDLE is not evaluated.
  - The NUM_TO_WRITE-th write and done never occur in the same cycle; done follows the write by one cycle.
- **Reset:** takes effect mid-capture. State returns to IDLE and no further writes occur. A partial burst already in the FIFO is not retracted.

## Timing
- Reset values:
  - din=0, wr_en=0, busy=0, done=0, overflow=0.
  - Counter=0, phase=0, prev_valid=0.
- wr_en/din are registered: latency is 1 cycle from the sample_valid edge to the write strobe.
- wr_en is high for exactly one cycle per written sample, never more than once per input sample.
- `full` is sampled in the candidate cycle. Because wr_en follows one cycle later, the FIFO must provide one word of slack (prog_full or depth ≥ NUM_TO_WRITE+1).
- busy rises the cycle after arm and falls on the cycle done pulses.
- Back-to-back capture is legal: arm is accepted in the cycle done is high.

## Configuration
- **ADC_CAPTURE_DECIM_EN defined:**
  - The decim port exists.
  - The phase counter advances on each valid sample in CAPTURE and wraps at decim-1; only phase-0 samples are candidates.
  - decim=0 or 1 means no decimation.
  - The triggering sample is always phase 0.
  - Trigger evaluation uses every sample regardless of decim.
  - A dropped (full) sample still advances the phase.
- **Not defined:** the decim port and phase logic are absent, and every valid sample in CAPTURE is a candidate.

## Structure
- **Package adc_capture_pkg:**
  - State enum (IDLE, ARMED, CAPTURE).
  - Trigger-mode constants TRIG_IMMEDIATE=0, TRIG_RISING=1.
  - DATA_WIDTH default.
- **Sub-module adc_trig_detect:**
  - Holds the prev-sample register, prev_valid, and the signed crossing comparator.
  - Outputs a one-cycle `trig` flag.
  - The top level owns the FSM, counter, decimation, and the FIFO interface.

## Test plan
- **Immediate burst:** trig_mode=0, NUM_TO_WRITE=10, arm, then samples 1..20 valid every cycle → exactly 10 wr_en pulses with din 1..10, done one cycle after the last write, busy low afterwards.
- **Rising trigger:** trig_level=100, sample ramp 90,95,99,100,105… → first din=100. Samples above level already present at arm (150,150,…) never trigger until the signal falls below 100 and recrosses it.
- **Full during capture:** hold full=1 for samples 4–5 → those samples are dropped, overflow=1 stays set, 10 writes still complete (din 1,2,3,6,…,12), overflow clears on the next arm.
- **Decimation (macro on):** decim=3, immediate mode → din = 1,4,7,…,28; 10 writes total.
- **Reset mid-capture:** rst after 4 writes → wr_en=0 next cycle, all outputs at reset values, state IDLE. A fresh arm then yields a full 10-word burst.
- **Re-arm/ignored arm:**
  - arm in ARMED clears prev_valid: a crossing that straddles the arm cycle does not fire.
  - arm during CAPTURE does not change the write count.
